ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage RV32I pipeline, directly downstream of the ALU control decoder. It consumes the 4-bit ALU operation code, operands and branch info, computes the ALU result and resolves the branch. All results are registered into the EX/MEM pipeline register, with stall (hold) and flush (bubble) control from the hazard unit.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ID/EX slot holds a real instruction
stall  input  1  hold EX/MEM contents (hazard unit)
flush  input  1  replace next EX/MEM contents with a bubble
alu_ctrl  input  4  ALU operation code
is_branch  input  1  instruction is a conditional branch
funct3  input  3  branch condition selector
op_a  input  XLEN  ALU operand A (forwarded rs1 or PC)
op_b  input  XLEN  ALU operand B (forwarded rs2 or immediate)
pc  input  XLEN  instruction PC
imm  input  XLEN  sign-extended branch offset
rd_in  input  REG_ADDR_W  destination register
reg_write_in  input  1  writes rd
exm_valid  output  1  EX/MEM slot valid
exm_result  output  XLEN  registered ALU result
exm_rd  output  REG_ADDR_W  registered rd
exm_reg_write  output  1  registered write enable, gated by valid
exm_zero  output  1  registered (result == 0)
exm_branch_taken  output  1  registered branch decision
exm_branch_target  output  XLEN  registered pc + imm
exm_illegal  output  1  registered undefined alu_ctrl flag

Behaviour:
- Reset (rst_n low, async): every output 0; takes effect immediately, independent of clk.
- Combinational ALU on alu_ctrl:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1000 XOR
  - 0111 SLT (signed, result 0/1); 1010 SLTU (unsigned, 0/1)
  - 1001 SLL; 1011 SRL; 1100 SRA; shift amount = op_b[4:0]
  - Add/sub wrap modulo 2^XLEN; no overflow flag.
  - Any other code or X: result 0, illegal=1 (only when in_valid).
- Branch decision (only when in_valid & is_branch), from ALU result:
  - funct3 000 BEQ: result==0; 001 BNE: result!=0
  - 100 BLT / 110 BLTU: result[0]==1; 101 BGE / 111 BGEU: result[0]==0
  - 010/011: not taken, illegal=1
- branch_target = pc + imm, modulo 2^XLEN.
- Register update priority each rising edge: flush > stall > load.
  - flush: exm_valid, exm_reg_write, exm_branch_taken and exm_illegal = 0; other fields don't-care (implementation drives 0).
  - stall (no flush): all EX/MEM outputs hold.
  - otherwise load: exm_valid=in_valid; exm_reg_write=reg_write_in & in_valid & (rd_in!=0); remaining fields from the combinational results.
- in_valid=0 loads a bubble: valid, reg_write, taken and illegal all 0.
- Latency: exactly 1 cycle from inputs to EX/MEM outputs; throughput 1 per cycle when not stalled.
- Simultaneous flush+stall: flush wins.
- Reset released mid-stream: first edge after release loads normally.
- No internal state besides the EX/MEM register.

Test Plan:
- ADD: op_a=0x7FFFFFFF, op_b=1, alu_ctrl=0010, in_valid=1 -> next cycle exm_result=0x80000000, exm_zero=0, exm_valid=1.
- SRA/SRL: op_a=0x80000000, op_b=0x24 (shamt 4), 1100 -> 0xF8000000; same with 1011 -> 0x08000000.
- BLT: op_a=-1, op_b=1, alu_ctrl=0111, is_branch=1, funct3=100, pc=0x100, imm=0x20 -> exm_branch_taken=1, target=0x120. Same operands with 1010/110 (BLTU) -> taken=0.
- Stall then flush: load ADD (result 5), stall=1 for 3 cycles -> outputs hold 5. Assert flush together with stall -> exm_valid=0, exm_reg_write=0.
- rd_in=0, reg_write_in=1 -> exm_reg_write=0. alu_ctrl=1111 -> exm_illegal=1, exm_result=0.
- Async reset: pull rst_n low mid-cycle after a valid load -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch resolution and the EX/MEM pipeline register.
// Stall holds the register, flush turns the next load into a bubble (flush wins).
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [3:0]            alu_ctrl,
  input  logic                  is_branch,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  output logic                  exm_valid,
  output logic [XLEN-1:0]       exm_result,
  output logic [REG_ADDR_W-1:0] exm_rd,
  output logic                  exm_reg_write,
  output logic                  exm_zero,
  output logic                  exm_branch_taken,
  output logic [XLEN-1:0]       exm_branch_target,
  output logic                  exm_illegal
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_XOR  = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SRA  = 4'b1100
  } alu_op_e;

  logic [XLEN-1:0] alu_result;
  logic            alu_bad;
  logic            br_cond;
  logic            br_bad;
  logic [4:0]      shamt;

  assign shamt = op_b[4:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_result = '0;
    alu_bad    = 1'b0;
    case (alu_ctrl)
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
      // Undefined or unknown codes fall here, including X.
      default:  alu_bad = 1'b1;
    endcase
  end

  // Branches are resolved from the comparison the decoder already selected.
  always_comb begin
    br_cond = 1'b0;
    br_bad  = 1'b0;
    case (funct3)
      3'b000:          br_cond = (alu_result == '0);
      3'b001:          br_cond = (alu_result != '0);
      3'b100, 3'b110:  br_cond = alu_result[0];
      3'b101, 3'b111:  br_cond = ~alu_result[0];
      default:         br_bad  = 1'b1;
    endcase
  end

  logic take_branch;
  logic illegal_now;

  assign take_branch = in_valid & is_branch & br_cond;
  assign illegal_now = in_valid & (alu_bad | (is_branch & br_bad));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_valid         <= 1'b0;
      exm_result        <= '0;
      exm_rd            <= '0;
      exm_reg_write     <= 1'b0;
      exm_zero          <= 1'b0;
      exm_branch_taken  <= 1'b0;
      exm_branch_target <= '0;
      exm_illegal       <= 1'b0;
    end else if (flush) begin
      exm_valid         <= 1'b0;
      exm_result        <= '0;
      exm_rd            <= '0;
      exm_reg_write     <= 1'b0;
      exm_zero          <= 1'b0;
      exm_branch_taken  <= 1'b0;
      exm_branch_target <= '0;
      exm_illegal       <= 1'b0;
    end else if (!stall) begin
      exm_valid         <= in_valid;
      exm_result        <= alu_result;
      exm_rd            <= rd_in;
      exm_reg_write     <= reg_write_in & in_valid & (rd_in != '0);
      exm_zero          <= (alu_result == '0);
      exm_branch_taken  <= take_branch;
      exm_branch_target <= pc + imm;
      exm_illegal       <= illegal_now;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: each task drives one scenario and checks the
// EX/MEM outputs 1 time unit after the capturing edge.
module tb_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, stall, flush, is_branch, reg_write_in;
  logic [3:0]      alu_ctrl;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b, pc, imm;
  logic [RW-1:0]   rd_in;
  logic            exm_valid, exm_reg_write, exm_zero, exm_branch_taken, exm_illegal;
  logic [XLEN-1:0] exm_result, exm_branch_target;
  logic [RW-1:0]   exm_rd;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_ctrl(alu_ctrl), .is_branch(is_branch), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .pc(pc), .imm(imm), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .exm_valid(exm_valid), .exm_result(exm_result), .exm_rd(exm_rd),
    .exm_reg_write(exm_reg_write), .exm_zero(exm_zero),
    .exm_branch_taken(exm_branch_taken), .exm_branch_target(exm_branch_target),
    .exm_illegal(exm_illegal)
  );

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; is_branch = 0; reg_write_in = 0;
    alu_ctrl = 4'b0010; funct3 = 3'b000; op_a = 0; op_b = 0; pc = 0; imm = 0; rd_in = 0;
  endtask

  task automatic alu_op(input logic [3:0] ctrl, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [RW-1:0] rd, input logic we);
    idle();
    in_valid = 1; alu_ctrl = ctrl; op_a = a; op_b = b; rd_in = rd; reg_write_in = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    total_cnt++;
    if ({exm_valid, exm_result, exm_rd, exm_reg_write, exm_zero, exm_branch_taken,
         exm_branch_target, exm_illegal} !== '0)
      $display("FAIL reset_outputs: got valid=%b result=%h rd=%0d we=%b zero=%b taken=%b tgt=%h ill=%b, expected all 0",
               exm_valid, exm_result, exm_rd, exm_reg_write, exm_zero, exm_branch_taken,
               exm_branch_target, exm_illegal);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_add();
    alu_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
    step();
    total_cnt++;
    if (exm_result !== 32'h8000_0000 || exm_zero !== 1'b0 || exm_valid !== 1'b1 ||
        exm_reg_write !== 1'b1 || exm_rd !== 5'd3)
      $display("FAIL add_wrap: got result=%h zero=%b valid=%b we=%b rd=%0d, expected 80000000/0/1/1/3",
               exm_result, exm_zero, exm_valid, exm_reg_write, exm_rd);
    else pass_cnt++;
  endtask

  task automatic test_shift();
    alu_op(4'b1100, 32'h8000_0000, 32'h24, 5'd4, 1'b1);
    step();
    total_cnt++;
    if (exm_result !== 32'hF800_0000)
      $display("FAIL sra: got %h expected f8000000", exm_result);
    else pass_cnt++;
    alu_op(4'b1011, 32'h8000_0000, 32'h24, 5'd4, 1'b1);
    step();
    total_cnt++;
    if (exm_result !== 32'h0800_0000)
      $display("FAIL srl: got %h expected 08000000", exm_result);
    else pass_cnt++;
    alu_op(4'b1001, 32'h0000_0003, 32'h1F, 5'd4, 1'b1);
    step();
    total_cnt++;
    if (exm_result !== 32'h8000_0000)
      $display("FAIL sll: got %h expected 80000000", exm_result);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    alu_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
    is_branch = 1; funct3 = 3'b100; pc = 32'h100; imm = 32'h20;
    step();
    total_cnt++;
    if (exm_branch_taken !== 1'b1 || exm_branch_target !== 32'h120 || exm_result !== 32'h1)
      $display("FAIL blt: got taken=%b tgt=%h result=%h expected 1/00000120/00000001",
               exm_branch_taken, exm_branch_target, exm_result);
    else pass_cnt++;
    alu_op(4'b1010, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
    is_branch = 1; funct3 = 3'b110; pc = 32'h100; imm = 32'h20;
    step();
    total_cnt++;
    if (exm_branch_taken !== 1'b0 || exm_result !== 32'h0 || exm_illegal !== 1'b0)
      $display("FAIL bltu: got taken=%b result=%h ill=%b expected 0/00000000/0",
               exm_branch_taken, exm_result, exm_illegal);
    else pass_cnt++;
    // BGE on -1 < 1: comparison true, so not taken; target wraps modulo 2^32.
    alu_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
    is_branch = 1; funct3 = 3'b101; pc = 32'hFFFF_FFF0; imm = 32'h20;
    step();
    total_cnt++;
    if (exm_branch_taken !== 1'b0 || exm_branch_target !== 32'h10)
      $display("FAIL bge_wrap: got taken=%b tgt=%h expected 0/00000010", exm_branch_taken, exm_branch_target);
    else pass_cnt++;
    alu_op(4'b0110, 32'd5, 32'd5, 5'd0, 1'b0);
    is_branch = 1; funct3 = 3'b000; pc = 32'h40; imm = 32'hFFFF_FFF8;
    step();
    total_cnt++;
    if (exm_branch_taken !== 1'b1 || exm_zero !== 1'b1 || exm_branch_target !== 32'h38)
      $display("FAIL beq: got taken=%b zero=%b tgt=%h expected 1/1/00000038",
               exm_branch_taken, exm_zero, exm_branch_target);
    else pass_cnt++;
    alu_op(4'b0110, 32'd5, 32'd5, 5'd0, 1'b0);
    is_branch = 1; funct3 = 3'b010;
    step();
    total_cnt++;
    if (exm_branch_taken !== 1'b0 || exm_illegal !== 1'b1)
      $display("FAIL branch_funct3_bad: got taken=%b ill=%b expected 0/1", exm_branch_taken, exm_illegal);
    else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    alu_op(4'b0010, 32'd2, 32'd3, 5'd7, 1'b1);
    step();
    alu_op(4'b0010, 32'd100, 32'd1, 5'd9, 1'b1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (exm_result !== 32'd5 || exm_valid !== 1'b1 || exm_rd !== 5'd7 || exm_reg_write !== 1'b1)
        $display("FAIL stall_hold_%0d: got result=%h valid=%b rd=%0d we=%b expected 00000005/1/7/1",
                 i, exm_result, exm_valid, exm_rd, exm_reg_write);
      else pass_cnt++;
    end
    flush = 1;
    step();
    total_cnt++;
    if (exm_valid !== 1'b0 || exm_reg_write !== 1'b0 || exm_branch_taken !== 1'b0 || exm_illegal !== 1'b0)
      $display("FAIL flush_over_stall: got valid=%b we=%b taken=%b ill=%b expected all 0",
               exm_valid, exm_reg_write, exm_branch_taken, exm_illegal);
    else pass_cnt++;
  endtask

  task automatic test_rd_zero_illegal();
    alu_op(4'b0001, 32'hF0, 32'h0F, 5'd0, 1'b1);
    step();
    total_cnt++;
    if (exm_reg_write !== 1'b0 || exm_valid !== 1'b1 || exm_result !== 32'hFF)
      $display("FAIL rd_zero: got we=%b valid=%b result=%h expected 0/1/000000ff",
               exm_reg_write, exm_valid, exm_result);
    else pass_cnt++;
    alu_op(4'b1111, 32'h1234, 32'h5678, 5'd2, 1'b1);
    step();
    total_cnt++;
    if (exm_illegal !== 1'b1 || exm_result !== 32'h0 || exm_zero !== 1'b1)
      $display("FAIL illegal_op: got ill=%b result=%h zero=%b expected 1/00000000/1",
               exm_illegal, exm_result, exm_zero);
    else pass_cnt++;
    alu_op(4'b1111, 32'h1234, 32'h5678, 5'd2, 1'b1);
    in_valid = 0;
    step();
    total_cnt++;
    if (exm_illegal !== 1'b0 || exm_valid !== 1'b0 || exm_reg_write !== 1'b0)
      $display("FAIL bubble: got ill=%b valid=%b we=%b expected 0/0/0", exm_illegal, exm_valid, exm_reg_write);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    alu_op(4'b0110, 32'd3, 32'd5, 5'd1, 1'b1);
    step();
    total_cnt++;
    if (exm_result !== 32'hFFFF_FFFE || exm_rd !== 5'd1)
      $display("FAIL b2b_sub: got result=%h rd=%0d expected fffffffe/1", exm_result, exm_rd);
    else pass_cnt++;
    alu_op(4'b1000, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd2, 1'b1);
    step();
    total_cnt++;
    if (exm_result !== 32'hF0F0_F0F0 || exm_rd !== 5'd2)
      $display("FAIL b2b_xor: got result=%h rd=%0d expected f0f0f0f0/2", exm_result, exm_rd);
    else pass_cnt++;
    alu_op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd3, 1'b1);
    step();
    total_cnt++;
    if (exm_result !== 32'h0F00_0F00 || exm_rd !== 5'd3)
      $display("FAIL b2b_and: got result=%h rd=%0d expected 0f000f00/3", exm_result, exm_rd);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    alu_op(4'b0010, 32'd10, 32'd20, 5'd4, 1'b1);
    is_branch = 1; funct3 = 3'b001; pc = 32'h200; imm = 32'h8;
    step();
    total_cnt++;
    if (exm_valid !== 1'b1 || exm_result !== 32'd30 || exm_branch_taken !== 1'b1)
      $display("FAIL pre_reset_load: got valid=%b result=%h taken=%b expected 1/0000001e/1",
               exm_valid, exm_result, exm_branch_taken);
    else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total_cnt++;
    if ({exm_valid, exm_result, exm_rd, exm_reg_write, exm_zero, exm_branch_taken,
         exm_branch_target, exm_illegal} !== '0)
      $display("FAIL async_reset: got valid=%b result=%h rd=%0d we=%b tgt=%h, expected all 0",
               exm_valid, exm_result, exm_rd, exm_reg_write, exm_branch_target);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
    alu_op(4'b0010, 32'd1, 32'd1, 5'd6, 1'b1);
    step();
    total_cnt++;
    if (exm_valid !== 1'b1 || exm_result !== 32'd2 || exm_rd !== 5'd6)
      $display("FAIL post_reset_load: got valid=%b result=%h rd=%0d expected 1/00000002/6",
               exm_valid, exm_result, exm_rd);
    else pass_cnt++;
  endtask

  initial begin
    idle();
    test_reset();
    test_add();
    test_shift();
    test_branch();
    test_stall_flush();
    test_rd_zero_illegal();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
